datapath_gen: RTL and testbench

Parametrised successor to the lab-processor datapath: a WIDTH-bit bus-based datapath with NREG general registers (top register is the program counter), accumulator A, ALU result register G with status flags, memory address/data-out registers, and an optional iterative shift-add multiplier with start/busy/done handshake. It sits between the control FSM, which drives all enables and selects, and the memory interface (addr, dout, w). The shared bus is a single-source mux addressed by an encoded select.

---
 rtl/datapath_gen.sv | 165 ++++++++++++++++
 tb/tb_datapath_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_gen.sv
// datapath_gen: WIDTH-bit single-bus datapath with NREG registers (top one is the PC), A, G + flags, memory regs.
// Optional iterative shift-add multiplier is built when DATAPATH_GEN_MUL_EN is defined.
module datapath_gen #(
    parameter int WIDTH = 9,
    parameter int NREG  = 8,
    localparam int SW   = $clog2(NREG + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [NREG-1:0]  rin,
    input  logic [SW-1:0]    src_sel,
    input  logic             ain,
    input  logic             gin,
    input  logic [1:0]       alu_op,
    input  logic             addr_in,
    input  logic             dout_in,
    input  logic             w_d,
    input  logic             incr_pc,
    input  logic             mul_start,
    output logic [WIDTH-1:0] bus,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] addr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] pc,
    output logic             w,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             mul_busy,
    output logic             mul_done
);

    logic [WIDTH-1:0] r [NREG];
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   alu_res;
    logic             alu_c;

    // Single-source bus; unused select codes drive zero
    always_comb begin
        bus = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (src_sel == SW'(i)) bus = r[i];
        end
        if (src_sel == SW'(NREG))     bus = g;
        if (src_sel == SW'(NREG + 1)) bus = din;
        if (src_sel == SW'(NREG + 2)) bus = p;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        unique case (alu_op)
            2'b00: begin
                alu_res = {1'b0, a} + {1'b0, bus};
                alu_c   = alu_res[WIDTH];
            end
            2'b01: begin
                alu_res = {1'b0, a} - {1'b0, bus};
                alu_c   = ~alu_res[WIDTH];
            end
            2'b10:   alu_res = {1'b0, a & bus};
            default: alu_res = {1'b0, bus};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) r[i] <= '0;
            a      <= '0;
            g      <= '0;
            addr   <= '0;
            dout   <= '0;
            w      <= 1'b0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREG - 1; i++) begin
                if (rin[i]) r[i] <= bus;
            end
            if (rin[NREG-1])  r[NREG-1] <= bus;
            else if (incr_pc) r[NREG-1] <= r[NREG-1] + WIDTH'(1);
            if (ain)     a    <= bus;
            if (addr_in) addr <= bus;
            if (dout_in) dout <= bus;
            w <= w_d;
            if (gin) begin
                g      <= alu_res[WIDTH-1:0];
                flag_z <= (alu_res[WIDTH-1:0] == '0);
                flag_n <= alu_res[WIDTH-1];
                flag_c <= alu_c;
            end
        end
    end

    assign pc = r[NREG-1];

`ifdef DATAPATH_GEN_MUL_EN
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
    localparam int CW = $clog2(WIDTH + 1);

    mul_state_t       state, state_nx;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nx;
    logic [CW-1:0]    cnt;
    logic             last_iter;

    assign acc_nx    = acc + (mplier[0] ? mcand : '0);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        mul_busy = 1'b0;
        mul_done = 1'b0;
        unique case (state)
            IDLE: if (mul_start) state_nx = RUN;
            RUN: begin
                mul_busy = 1'b1;
                if (last_iter) state_nx = DONE;
            end
            DONE: begin
                mul_done = 1'b1;
                state_nx = mul_start ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operands are captured only outside RUN, so a start during RUN is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p      <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last_iter) p <= acc_nx;
        end else if (mul_start) begin
            mcand  <= a;
            mplier <= bus;
            acc    <= '0;
            cnt    <= '0;
        end
    end
`else
    logic unused_mul_start;

    assign unused_mul_start = mul_start;
    assign p        = '0;
    assign mul_busy = 1'b0;
    assign mul_done = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_gen.sv
// Self-checking bench for datapath_gen: directed ALU/PC/multiplier cases plus random traffic against a behavioural model.
module tb_datapath_gen;
    localparam int WIDTH = 9;
    localparam int NREG  = 8;
    localparam int SW    = $clog2(NREG + 3);
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] din;
    logic [NREG-1:0]  rin;
    logic [SW-1:0]    src_sel;
    logic             ain, gin, addr_in, dout_in, w_d, incr_pc, mul_start;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] bus, a, g, addr, dout, pc;
    logic             w, flag_z, flag_n, flag_c, mul_busy, mul_done;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_r [NREG];
    int m_a, m_g, m_addr, m_dout, m_p, m_pending, m_busy_left;
    bit m_w, m_z, m_n, m_c, m_done;

    datapath_gen #(.WIDTH(WIDTH), .NREG(NREG)) dut (
        .clk(clk), .rst(rst), .din(din), .rin(rin), .src_sel(src_sel),
        .ain(ain), .gin(gin), .alu_op(alu_op), .addr_in(addr_in), .dout_in(dout_in),
        .w_d(w_d), .incr_pc(incr_pc), .mul_start(mul_start),
        .bus(bus), .a(a), .g(g), .addr(addr), .dout(dout), .pc(pc), .w(w),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .mul_busy(mul_busy), .mul_done(mul_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    function automatic int model_bus();
        int s = int'(src_sel);
        if (s < NREG)      return m_r[s];
        if (s == NREG)     return m_g;
        if (s == NREG + 1) return int'(din);
`ifdef DATAPATH_GEN_MUL_EN
        if (s == NREG + 2) return m_p;
`endif
        return 0;
    endfunction

    task automatic idle_inputs();
        din = '0; rin = '0; src_sel = '0; ain = 0; gin = 0; alu_op = 2'b00;
        addr_in = 0; dout_in = 0; w_d = 0; incr_pc = 0; mul_start = 0;
    endtask

    // Advance the model by one clock from the current inputs, then clock the DUT
    task automatic step();
        int b, res;
        bit c;
        b = model_bus();
        c = 0;
        case (alu_op)
            2'd0: begin res = m_a + b; c = (res >= MOD); res = res % MOD; end
            2'd1: begin c = (m_a >= b); res = (m_a - b + MOD) % MOD; end
            2'd2: res = m_a & b;
            default: res = b;
        endcase
        if (rst) begin
            foreach (m_r[i]) m_r[i] = 0;
            m_a = 0; m_g = 0; m_addr = 0; m_dout = 0; m_p = 0;
            m_w = 0; m_z = 0; m_n = 0; m_c = 0; m_busy_left = 0; m_done = 0;
        end else begin
`ifdef DATAPATH_GEN_MUL_EN
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) begin m_done = 1; m_p = m_pending; end
            end else begin
                m_done = 0;
                if (mul_start) begin m_pending = (m_a * b) % MOD; m_busy_left = WIDTH; end
            end
`endif
            for (int i = 0; i < NREG; i++) if (rin[i]) m_r[i] = b;
            if (!rin[NREG-1] && incr_pc) m_r[NREG-1] = (m_r[NREG-1] + 1) % MOD;
            if (ain) m_a = b;
            if (addr_in) m_addr = b;
            if (dout_in) m_dout = b;
            m_w = w_d;
            if (gin) begin
                m_g = res; m_z = (res == 0); m_n = (res >= MOD / 2); m_c = c;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input int v);
        src_sel = SW'(NREG + 1); din = WIDTH'(v); ain = 1;
        step();
        ain = 0;
    endtask

    task automatic alu(input logic [1:0] op, input int v);
        src_sel = SW'(NREG + 1); din = WIDTH'(v); alu_op = op; gin = 1;
        step();
        gin = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        step(); step();
        rst = 0;
        for (int k = 0; k < 12; k++) begin
            din = WIDTH'($urandom); rin = NREG'($urandom); src_sel = SW'(NREG + 1);
            ain = 1; gin = 1; addr_in = 1; dout_in = 1; w_d = 1; mul_start = (k == 3);
            step();
        end
        rst = 1;
        step(); step();
        rst = 0; idle_inputs();
        #1;
        checks++;
        if ({a, g, addr, dout, pc} !== '0) begin
            errors++;
            $display("FAIL reset_regs: got a=%h g=%h addr=%h dout=%h pc=%h, expected all 0", a, g, addr, dout, pc);
        end
        checks++;
        if ({w, flag_z, flag_n, flag_c, mul_busy, mul_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got w,z,n,c,busy,done=%b, expected 000000",
                     {w, flag_z, flag_n, flag_c, mul_busy, mul_done});
        end
        checks++;
        if (bus !== '0) begin
            errors++;
            $display("FAIL reset_bus_r0: got %h expected 0", bus);
        end
        src_sel = SW'(NREG + 1); din = 9'h0A5; #1;
        checks++;
        if (bus !== 9'h0A5) begin
            errors++;
            $display("FAIL reset_bus_din: got %h expected 0a5", bus);
        end
    endtask

    task automatic test_add();
        idle_inputs();
        src_sel = SW'(NREG + 1); din = 9'h005; rin = 1; step(); rin = 0;
        src_sel = 0; ain = 1; step(); ain = 0;
        alu(2'b00, 9'h003);
        checks++;
        if ({g, flag_z, flag_n, flag_c} !== {9'h008, 3'b000}) begin
            errors++;
            $display("FAIL add_5_3: got g=%h znc=%b%b%b expected g=008 znc=000", g, flag_z, flag_n, flag_c);
        end
        load_a(9'h1FF);
        alu(2'b00, 9'h001);
        checks++;
        if ({g, flag_z, flag_c} !== {9'h000, 2'b11}) begin
            errors++;
            $display("FAIL add_wrap: got g=%h z=%b c=%b expected g=000 z=1 c=1", g, flag_z, flag_c);
        end
        src_sel = SW'(NREG); #1;
        checks++;
        if (bus !== 9'h000) begin
            errors++;
            $display("FAIL bus_g: got %h expected 000", bus);
        end
    endtask

    task automatic test_sub_and();
        idle_inputs();
        load_a(9'h003);
        alu(2'b01, 9'h005);
        checks++;
        if ({g, flag_z, flag_n, flag_c} !== {9'h1FE, 3'b010}) begin
            errors++;
            $display("FAIL sub_neg: got g=%h znc=%b%b%b expected g=1fe znc=010", g, flag_z, flag_n, flag_c);
        end
        load_a(9'h005);
        alu(2'b01, 9'h005);
        checks++;
        if ({g, flag_z, flag_n, flag_c} !== {9'h000, 3'b101}) begin
            errors++;
            $display("FAIL sub_eq: got g=%h znc=%b%b%b expected g=000 znc=101", g, flag_z, flag_n, flag_c);
        end
        load_a(9'h0F0);
        alu(2'b10, 9'h03C);
        checks++;
        if ({g, flag_z, flag_n, flag_c} !== {9'h030, 3'b000}) begin
            errors++;
            $display("FAIL and: got g=%h znc=%b%b%b expected g=030 znc=000", g, flag_z, flag_n, flag_c);
        end
        src_sel = SW'(NREG + 1); din = 9'h1AB; alu_op = 2'b00; gin = 0; step();
        checks++;
        if ({g, flag_z, flag_n, flag_c} !== {9'h030, 3'b000}) begin
            errors++;
            $display("FAIL flags_hold: got g=%h znc=%b%b%b expected g=030 znc=000", g, flag_z, flag_n, flag_c);
        end
    endtask

    task automatic test_pc();
        idle_inputs();
        src_sel = SW'(NREG + 1); din = 9'h1FE; rin = NREG'(1) << (NREG - 1); step(); rin = 0;
        incr_pc = 1; step();
        checks++;
        if (pc !== 9'h1FF) begin
            errors++;
            $display("FAIL pc_incr: got %h expected 1ff", pc);
        end
        step();
        checks++;
        if (pc !== 9'h000) begin
            errors++;
            $display("FAIL pc_wrap: got %h expected 000", pc);
        end
        din = 9'h040; rin = NREG'(1) << (NREG - 1); step();
        idle_inputs();
        checks++;
        if (pc !== 9'h040) begin
            errors++;
            $display("FAIL pc_load_priority: got %h expected 040", pc);
        end
    endtask

`ifdef DATAPATH_GEN_MUL_EN
    task automatic test_multiply();
        int busy_cnt;
        idle_inputs();
        load_a(13);
        src_sel = SW'(NREG + 1); din = 11; mul_start = 1; step(); mul_start = 0;
        busy_cnt = 0;
        for (int k = 0; k < 2 * WIDTH && mul_busy === 1'b1; k++) begin
            if (mul_done !== 1'b0) busy_cnt = -100;
            busy_cnt++;
            step();
        end
        checks++;
        if (busy_cnt !== WIDTH) begin
            errors++;
            $display("FAIL mul_busy_len: got %0d expected %0d", busy_cnt, WIDTH);
        end
        src_sel = SW'(NREG + 2); #1;
        checks++;
        if ({mul_busy, mul_done, bus} !== {2'b01, 9'd143}) begin
            errors++;
            $display("FAIL mul_13x11: got busy=%b done=%b p=%0d expected busy=0 done=1 p=143", mul_busy, mul_done, bus);
        end
        step();
        checks++;
        if ({mul_busy, mul_done, bus} !== {2'b00, 9'd143}) begin
            errors++;
            $display("FAIL mul_done_once: got busy=%b done=%b p=%0d expected busy=0 done=0 p=143", mul_busy, mul_done, bus);
        end
        load_a(30);
        src_sel = SW'(NREG + 1); din = 20; mul_start = 1; step(); mul_start = 0;
        step(); step();
        din = 7; mul_start = 1; step(); mul_start = 0;
        while (mul_busy === 1'b1 && busy_cnt < 4 * WIDTH) begin busy_cnt++; step(); end
        src_sel = SW'(NREG + 2); #1;
        checks++;
        if ({mul_done, bus} !== {1'b1, 9'd88}) begin
            errors++;
            $display("FAIL mul_30x20_ignore_start: got done=%b p=%0d expected done=1 p=88", mul_done, bus);
        end
        src_sel = SW'(NREG + 1); din = 3; mul_start = 1; step(); mul_start = 0;
        checks++;
        if ({mul_busy, mul_done} !== 2'b10) begin
            errors++;
            $display("FAIL mul_back_to_back: got busy=%b done=%b expected busy=1 done=0", mul_busy, mul_done);
        end
        step(); step(); step();
        rst = 1; step(); rst = 0;
        src_sel = SW'(NREG + 2); #1;
        checks++;
        if ({mul_busy, mul_done, bus} !== {2'b00, 9'd0}) begin
            errors++;
            $display("FAIL mul_reset: got busy=%b done=%b p=%0d expected 0 0 0", mul_busy, mul_done, bus);
        end
        for (int k = 0; k < WIDTH + 2; k++) step();
        checks++;
        if ({mul_busy, mul_done} !== 2'b00) begin
            errors++;
            $display("FAIL mul_reset_idle: got busy=%b done=%b expected 00", mul_busy, mul_done);
        end
    endtask
`else
    task automatic test_no_multiplier();
        int seen = 0;
        idle_inputs();
        load_a(13);
        src_sel = SW'(NREG + 1); din = 11; mul_start = 1;
        for (int k = 0; k < WIDTH + 3; k++) begin
            step();
            if (mul_busy !== 1'b0 || mul_done !== 1'b0) seen++;
        end
        mul_start = 0;
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL nomul_status: got %0d cycles with busy/done set expected 0", seen);
        end
        src_sel = SW'(NREG + 2); #1;
        checks++;
        if (bus !== '0) begin
            errors++;
            $display("FAIL nomul_bus: got %h expected 000", bus);
        end
    endtask
`endif

    task automatic test_random();
        int bad = 0;
        logic [6*WIDTH+5:0] got, exp;
        idle_inputs();
        for (int k = 0; k < 400; k++) begin
            din = WIDTH'($urandom); rin = NREG'($urandom & $urandom);
            src_sel = SW'($urandom); alu_op = 2'($urandom);
            ain = 1'($urandom); gin = 1'($urandom); addr_in = 1'($urandom);
            dout_in = 1'($urandom); w_d = 1'($urandom); incr_pc = 1'($urandom);
            mul_start = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (int'(bus) !== model_bus()) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_bus[%0d]: got %h expected %h sel=%0d", k, bus, model_bus(), src_sel);
            end
            step();
            got = {bus, a, g, addr, dout, pc, w, flag_z, flag_n, flag_c, mul_busy, mul_done};
            exp = {bus, WIDTH'(m_a), WIDTH'(m_g), WIDTH'(m_addr), WIDTH'(m_dout), WIDTH'(m_r[NREG-1]),
                   m_w, m_z, m_n, m_c, (m_busy_left > 0), m_done};
            checks++;
            if (got !== exp) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL rand_state[%0d]: got %h expected %h", k, got, exp);
            end
        end
        idle_inputs();
    endtask

    initial begin
        foreach (m_r[i]) m_r[i] = 0;
        m_a = 0; m_g = 0; m_addr = 0; m_dout = 0; m_p = 0; m_pending = 0; m_busy_left = 0;
        m_w = 0; m_z = 0; m_n = 0; m_c = 0; m_done = 0;
        test_reset();
        test_add();
        test_sub_and();
        test_pc();
`ifdef DATAPATH_GEN_MUL_EN
        test_multiply();
`else
        test_no_multiplier();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
